// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH  = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SELECT = 1'b1
  } spi_rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with registered
// rise/fall pulses taken from the last two synchronizer stages.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_q;
  logic                   fall_q;

  // Shift the pin through the chain; the edge pulses last exactly one clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
      fall_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0, MSB-first slave: receives words on mosi, returns words on miso,
// all logic oversampled in the clk domain.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  done,
  output logic                  busy,
  output logic                  abort
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;
  logic mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_rx_state_t         state_q,    state_d;
  logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
  logic                  miso_q,     miso_d;
  logic                  miso_oe_q,  miso_oe_d;
  logic                  done_q,     done_d;
  logic                  busy_q,     busy_d;
  logic                  abort_q,    abort_d;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_ss_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (ss),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // Plain synchronizer for mosi; data is stable for half an sclk around the rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Next-state logic: bit shifting, word completion, frame abort.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    // Output enable tracks synchronized ss through its edges.
    if (ss_fall) begin
      miso_oe_d = 1'b1;
    end
    if (ss_rise) begin
      miso_oe_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = SELECT;
          bit_cnt_d  = '0;
          tx_shift_d = tx_data;
          miso_d     = tx_data[DATA_WIDTH-1];
        end
      end

      SELECT: begin
        if (sclk_rise) begin
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            done_d    = 1'b1;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
          end else begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            busy_d     = 1'b1;
          end
        end

        // A falling edge with no bits pending follows a completed word:
        // reload so the next word's MSB is on miso before its first rise.
        if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            tx_shift_d = tx_data;
            miso_d     = tx_data[DATA_WIDTH-1];
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end

        // Count after this cycle's rise decides whether bits are stranded.
        if (ss_rise) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (bit_cnt_d != '0) begin
            abort_d = 1'b1;
          end
          bit_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign abort   = abort_q;

endmodule
